// File: rtl/pack_8_n_if.sv
// Lane-packer bus bundle: the narrow lane input side and the packed-word
// output side, each with its own valid/ready handshake.
interface pack_8_n_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
);
  localparam int OUT_W = IN_W * RATIO;

  logic [IN_W-1:0]  data_in;
  logic             valid_in;
  logic             in_ready;
  logic             flush_in;
  logic [OUT_W-1:0] data_out;
  logic [RATIO-1:0] keep_out;
  logic             valid_out;
  logic             out_ready;

  // Upstream de-serialiser plus downstream sink, as seen by the environment.
  modport master (
    output data_in, valid_in, flush_in, out_ready,
    input  in_ready, data_out, keep_out, valid_out
  );

  // The packer itself.
  modport slave (
    input  data_in, valid_in, flush_in, out_ready,
    output in_ready, data_out, keep_out, valid_out
  );
endinterface

// File: rtl/pack_8_n.sv
// Lane packer: collects RATIO lanes of IN_W bits MSB-first into one word,
// with output back-pressure, partial-word flush (explicit or after an idle
// timeout) and a per-lane keep mask marking which lanes of the word are real.
module pack_8_n #(
  parameter int IN_W     = 8,
  parameter int RATIO    = 4,
  parameter int IDLE_CYC = 4
) (
  input  logic          clk_4f,
  input  logic          reset,
  pack_8_n_if.slave     bus
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int ACC_W = OUT_W - IN_W;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int LW    = CW + 1;
  localparam int IW    = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic [OUT_W-1:0] data_out_q, data_out_d;
  logic [RATIO-1:0] keep_q, keep_d;
  logic             valid_q, valid_d;

  logic             in_ready;
  logic             accept;
  logic [LW-1:0]    lanes_n;
  logic             idle_step;
  logic [IW-1:0]    idle_next;
  logic             auto_flush;
  logic             emit;
  logic [OUT_W-1:0] held_w;
  logic [OUT_W-1:0] packed_w;
  logic [RATIO-1:0] packed_keep;

  // A new lane may only enter when the output register is free or being drained.
  assign in_ready      = !valid_q || bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.data_out  = data_out_q;
  assign bus.keep_out  = keep_q;
  assign bus.valid_out = valid_q;

  // Decide this edge's accept/emit and build the candidate output word.
  always_comb begin
    accept    = bus.valid_in && in_ready;
    lanes_n   = {1'b0, cnt_q} + LW'(accept);

    // The idle counter saturates; the timeout fires on the edge it reaches
    // IDLE_CYC, or later on the first edge the output side lets us through.
    idle_step  = (cnt_q != '0) && !accept && (idle_q != IW'(IDLE_CYC));
    idle_next  = idle_step ? idle_q + IW'(1) : idle_q;
    auto_flush = (IDLE_CYC != 0) && (idle_next == IW'(IDLE_CYC));

    emit = in_ready && (lanes_n != '0) &&
           ((lanes_n == LW'(RATIO)) || bus.flush_in || auto_flush);

    // Held lanes sit right-justified in the accumulator; left-justify them
    // so the first lane lands in the MSBs and unused lanes read as zero.
    held_w      = accept ? {acc_q, bus.data_in} : {{IN_W{1'b0}}, acc_q};
    packed_w    = held_w << (IN_W * (RATIO - int'(lanes_n)));
    packed_keep = ~({RATIO{1'b1}} >> lanes_n);

    acc_d      = acc_q;
    cnt_d      = cnt_q;
    idle_d     = idle_next;
    data_out_d = data_out_q;
    keep_d     = keep_q;
    valid_d    = valid_q;

    if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end

    if (emit) begin
      data_out_d = packed_w;
      keep_d     = packed_keep;
      valid_d    = 1'b1;
      acc_d      = '0;
      cnt_d      = '0;
      idle_d     = '0;
    end else if (accept) begin
      acc_d  = held_w[ACC_W-1:0];
      cnt_d  = lanes_n[CW-1:0];
      idle_d = '0;
    end
  end

  // State and registered outputs; reset discards any partial lanes at once.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      idle_q     <= '0;
      data_out_q <= '0;
      keep_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      data_out_q <= data_out_d;
      keep_q     <= keep_d;
      valid_q    <= valid_d;
    end
  end
endmodule
